// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: register map and address decode shared by the GPIO controller
package wb_gpio_pkg;
  localparam logic [31:0] OFF_DIR  = 32'h00;
  localparam logic [31:0] OFF_OUT  = 32'h04;
  localparam logic [31:0] OFF_IN   = 32'h08;
  localparam logic [31:0] OFF_SET  = 32'h0C;
  localparam logic [31:0] OFF_CLR  = 32'h10;
  localparam logic [31:0] OFF_EN   = 32'h14;
  localparam logic [31:0] OFF_RISE = 32'h18;
  localparam logic [31:0] OFF_FALL = 32'h1C;
  localparam logic [31:0] OFF_STAT = 32'h20;
  localparam int REG_NUM = 9;
  typedef enum logic [3:0] {
    R_DIR, R_OUT, R_IN, R_SET, R_CLR, R_EN, R_RISE, R_FALL, R_STAT, R_NONE = 4'(REG_NUM)
  } reg_e;
  function automatic reg_e reg_idx(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    case (off)
      OFF_DIR:  return R_DIR;
      OFF_OUT:  return R_OUT;
      OFF_IN:   return R_IN;
      OFF_SET:  return R_SET;
      OFF_CLR:  return R_CLR;
      OFF_EN:   return R_EN;
      OFF_RISE: return R_RISE;
      OFF_FALL: return R_FALL;
      OFF_STAT: return R_STAT;
      default:  return R_NONE;
    endcase
  endfunction
endpackage

// File: rtl/wb_gpio_irq_sync_edge.sv
// gpio_sync_edge: pad synchroniser, previous-sample register and post-reset edge arming
module gpio_sync_edge #(
  parameter int W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] pin,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise_raw,
  output logic [W-1:0] fall_raw
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM = CW'(SYNC_STAGES + 1);
  logic [W-1:0] ff [SYNC_STAGES];
  logic [W-1:0] prev;
  logic [CW-1:0] cnt;
  logic armed;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) ff[i] <= '0;
      prev <= '0;
      cnt <= '0;
    end else begin
      ff[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) ff[i] <= ff[i-1];
      prev <= sync;
      cnt <= armed ? cnt : cnt + 1'b1;
    end
  assign sync = ff[SYNC_STAGES-1];
  // edges are ignored until the chain has flushed its reset zeros
  assign armed = cnt == ARM;
  assign rise_raw = sync & ~prev & {W{armed}};
  assign fall_raw = ~sync & prev & {W{armed}};
endmodule

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: pipelined Wishbone GPIO with atomic set/clear and per-pin edge interrupts
module wb_gpio_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int GPIO_NUM = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_addr_i,
  input  logic [31:0]         wb_data_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic [31:0]         wb_data_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_oe_o,
  output logic                irq_o
);
  import wb_gpio_pkg::*;
  logic req, wr, unused_bits;
  reg_e idx;
  logic [31:0] wm, rd;
  logic [GPIO_NUM-1:0] bm, wd, w1c, ev, dir, out, en, rise_en, fall_en, stat;
  logic [GPIO_NUM-1:0] sync, rise_raw, fall_raw;
  assign req = wb_cyc_i & wb_stb_i;
  assign wr = req & wb_we_i;
  assign idx = reg_idx(wb_addr_i, BASE_ADDR);
  assign wm = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign bm = wm[GPIO_NUM-1:0];
  assign wd = wb_data_i[GPIO_NUM-1:0] & bm;
  assign w1c = (wr && idx == R_STAT) ? wd : '0;
  assign ev = ((rise_raw & rise_en) | (fall_raw & fall_en)) & ~dir;
  assign unused_bits = ^{wb_data_i, wm};
  assign wb_stall_o = 1'b0;
  assign gpio_out_o = out;
  assign gpio_oe_o = dir;
  gpio_sync_edge #(.W(GPIO_NUM), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .resetn(resetn),
    .pin(gpio_in_i),
    .sync(sync),
    .rise_raw(rise_raw),
    .fall_raw(fall_raw)
  );
  always_comb begin
    rd = '0;
    case (idx)
      R_DIR:   rd[GPIO_NUM-1:0] = dir;
      R_OUT:   rd[GPIO_NUM-1:0] = out;
      R_IN:    rd[GPIO_NUM-1:0] = sync;
      R_EN:    rd[GPIO_NUM-1:0] = en;
      R_RISE:  rd[GPIO_NUM-1:0] = rise_en;
      R_FALL:  rd[GPIO_NUM-1:0] = fall_en;
      R_STAT:  rd[GPIO_NUM-1:0] = stat;
      default: rd = '0;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wb_ack_o <= 1'b0;
      wb_data_o <= '0;
      irq_o <= 1'b0;
      dir <= '0;
      out <= '0;
      en <= '0;
      rise_en <= '0;
      fall_en <= '0;
      stat <= '0;
    end else begin
      wb_ack_o <= req;
      wb_data_o <= (req && !wb_we_i) ? rd : '0;
      if (wr && idx == R_DIR) dir <= (dir & ~bm) | wd;
      if (wr && idx == R_OUT) out <= (out & ~bm) | wd;
      else if (wr && idx == R_SET) out <= out | wd;
      else if (wr && idx == R_CLR) out <= out & ~wd;
      if (wr && idx == R_EN) en <= (en & ~bm) | wd;
      if (wr && idx == R_RISE) rise_en <= (rise_en & ~bm) | wd;
      if (wr && idx == R_FALL) fall_en <= (fall_en & ~bm) | wd;
      // a new edge in the same cycle as its clear keeps the bit set
      stat <= (stat & ~w1c) | ev;
      irq_o <= |(stat & en);
    end
endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
Parametrised Wishbone (pipelined, classic-compatible) GPIO controller with up to 32 pins, per-pin direction, atomic set/clear of outputs, synchronised input readback and per-pin edge-triggered interrupts. It sits on the SoC peripheral bus next to the UART and timer slaves and drives one level interrupt line to the CPU. Pad tristating is done at the top level from gpio_out_o/gpio_oe_o.

Parameters:
BASE_ADDR, 'h0, byte address of register 0; registers are at BASE_ADDR + 4*n.
GPIO_NUM, 8, number of pins, 1..32; register bits [31:GPIO_NUM] read 0 and ignore writes.
SYNC_STAGES, 2, input synchroniser depth, 2..4.

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_addr_i  in  32  byte address
wb_data_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_ack_o  out  1  acknowledge
wb_stall_o  out  1  stall, tied 0
wb_data_o  out  32  read data, registered
gpio_in_i  in  GPIO_NUM  asynchronous pad inputs
gpio_out_o  out  GPIO_NUM  output values
gpio_oe_o  out  GPIO_NUM  output enables (1 = drive)
irq_o  out  1  level interrupt, registered

Behaviour:
- Reset (async, resetn=0): all registers, synchroniser flops, prev-sample, arm counter, wb_ack_o, wb_data_o, irq_o = 0. gpio_oe_o=0, so all pins are inputs.
- Bus: request = cyc&stb. A request is accepted every cycle. wb_ack_o=1 exactly one cycle after each request, and wb_data_o is valid in the same cycle. A write takes effect in the register on the same edge as ack rises. Reads return state before that edge. wb_data_o=0 on non-read acks.
- Byte lanes: a write updates only the bytes with sel=1. SET/CLR/W1C use the masked data.
- Register map (offset):
  - 0x00 DIR rw: 1=output; drives gpio_oe_o.
  - 0x04 OUT rw: drives gpio_out_o.
  - 0x08 IN ro: synchronised pin value.
  - 0x0C OUT_SET wo: OUT |= data.
  - 0x10 OUT_CLR wo: OUT &= ~data.
  - 0x14 IRQ_EN rw.
  - 0x18 IRQ_RISE rw: arm rising edge per pin.
  - 0x1C IRQ_FALL rw: arm falling edge per pin.
  - 0x20 IRQ_STAT rw1c.
  - Unmapped addresses and wo registers are acked; reads return 0, writes have no effect.
- Input path: SYNC_STAGES flop chain per pin → sync. Register prev <= sync every cycle.
  - rise = sync & ~prev & RISE & ~DIR
  - fall = ~sync & prev & FALL & ~DIR
  - Both edges can be armed on the same pin.
- Arm counter: counts 0..SYNC_STAGES+1 after reset release, then saturates. Edge events are masked until it saturates, so a high pin at reset produces no spurious rise.
- IRQ_STAT update each cycle: STAT <= (STAT & ~w1c) | rise | fall. An edge event in the same cycle as a W1C of that bit sets the bit (set wins). STAT latches edges even if IRQ_EN=0.
- irq_o <= |(STAT & IRQ_EN), one cycle after STAT changes.
- Latency: pin change → IN readable after SYNC_STAGES+1 cycles. Edge → STAT bit set SYNC_STAGES+1 cycles after the pin change. irq_o follows one cycle after that.
- Changing DIR to output masks further edge detection on that pin. Existing STAT bits are retained.
- Reset asserted mid-transfer: ack is dropped immediately, and there is no ack after release.

Decomposition:
- Package wb_gpio_pkg:
  - register offset localparams (OFF_DIR … OFF_STAT)
  - register count
  - function to decode addr → register index.
- Sub-module gpio_sync_edge: parametrised in width and SYNC_STAGES. Holds the synchroniser chain, the prev register and the arm counter. Outputs sync, rise_raw and fall_raw; masking is done in the parent.

Test Plan:
- Reset with gpio_in_i=8'hFF, release, wait 10 cycles → IN reads 8'hFF, IRQ_STAT reads 0, irq_o=0, gpio_oe_o=0.
- Write DIR=8'h0F, OUT=8'hA5, then OUT_SET=8'h10, then OUT_CLR=8'h05 → gpio_out_o=8'hB0, gpio_oe_o=8'h0F. Each ack occurs exactly one cycle after its stb, with back-to-back stb on consecutive cycles.
- Write with sel=4'b0010, data=32'hFFFF_FFFF to DIR (GPIO_NUM=32) → DIR=32'h0000_FF00.
- RISE=8'h10, IRQ_EN=8'h10, then drive pin4 0→1 → STAT[4]=1 at SYNC_STAGES+1 cycles, irq_o=1 one cycle later. Write STAT=8'h10 → irq_o=0 one cycle after the write ack.
- FALL=RISE=8'h01, and pin0 falls in the same cycle as a W1C of bit 0 → STAT[0] stays 1. A rising edge on pin0 with DIR[0]=1 → no STAT change.
- Read 0x24 (unmapped) → ack, data 0. Assert resetn mid-request → ack stays 0 and all outputs clear asynchronously.
